// File: rtl/channel_mem_writer.sv
// channel_mem_writer: requantizes a stream of accumulator samples to int8 and stores them in a
// dual-read-port block RAM, so a layer's output can feed the next layer's channel reads.
module channel_mem_writer #(
    parameter int DEPTH  = 196,
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 20,
    parameter int SHIFT  = 7,
    parameter int RELU   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   frame_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ACC_W-1:0]  s_data,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [7:0]        dout1,
    output logic [7:0]        dout2,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic signed [ACC_W-1:0] MAXV = 127;
    localparam logic signed [ACC_W-1:0] MINV = -128;
    state_t state;
    logic [ADDR_W-1:0] wr_addr, last;
    logic [7:0] mem [DEPTH];
    logic signed [ACC_W-1:0] sh;
    logic [7:0] q;
    logic legal, hs;
    assign sh = $signed(s_data) >>> SHIFT;
    assign legal = frame_len != '0 && frame_len <= LEN_MAX;
    assign hs = s_valid & s_ready;
    always_comb q = (RELU != 0 && sh < 0) ? 8'h00 : (sh > MAXV) ? 8'h7f : (sh < MINV) ? 8'h80 : sh[7:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_addr <= '0;
            last    <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (legal) begin
                        state   <= WRITE;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                        wr_addr <= '0;
                        last    <= ADDR_W'(frame_len - 1'b1);
                    end else
                        err <= 1'b1;
                end
                WRITE: if (hs) begin
                    wr_addr <= wr_addr + 1'b1;
                    if (wr_addr == last) begin
                        state   <= FIN;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Storage has no reset so partially written frames survive a mid-frame reset.
    always_ff @(posedge clk)
        if (hs) mem[wr_addr] <= q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout1 <= '0;
            dout2 <= '0;
        end else if (load) begin
            dout1 <= mem[addr1];
            dout2 <= mem[addr2];
        end
    end
endmodule
